// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the DE2 SRAM controller.
package sram_controller_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int          SRAM_ADDR_W       = 18;
   localparam int          SRAM_DQ_W         = 16;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

   // 32-bit SRAM word index for an ARM byte address; wraps modulo 2^17 words.
   function automatic logic [16:0] sram_word(input logic [31:0] address,
                                             input logic [31:0] base);
      logic [31:0] offset;
      offset = address - base;
      return 17'(offset >> 2);
   endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter: counts 0..WAIT_CYCLES-1 and flags the last cycle.
module sram_wait_counter
   import sram_controller_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

   logic [3:0] count;

   assign terminal = (count == LAST);

   // Count while enabled, wrapping to 0 after the terminal cycle.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= 4'd0;
      end else if (enable) begin
         count <= terminal ? 4'd0 : count + 4'd1;
      end
   end

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit async SRAM accesses
// and stalls the pipeline (ready=0) while an access is in flight.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic                   wr_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N
);

   state_t               state;
   logic                 request;
   logic                 op_write;
   logic [16:0]          word;
   logic [15:0]          wdata_hi;
   logic [SRAM_DQ_W-1:0] dq_out;
   logic                 dq_oe;
   logic                 cnt_enable;
   logic                 terminal;

   assign request    = rd_en | wr_en;
   assign cnt_enable = (state == S_LOW) || (state == S_HIGH);

   assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DQ_W{1'bz}};
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

   sram_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait (
      .clk     (clk),
      .rst     (rst),
      .clear   (~cnt_enable),
      .enable  (cnt_enable),
      .terminal(terminal)
   );

   // Capture the request so later input changes cannot disturb the access.
   // NOTE: these latches need no reset; they are only read after IDLE loads them.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && request) begin
         op_write <= wr_en;
         word     <= sram_word(address, BASE_ADDR);
         wdata_hi <= write_data[31:16];
      end
   end

   // Access sequencer with registered SRAM pins and load result.
   // NOTE: non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         read_data <= 32'd0;
         SRAM_ADDR <= '0;
         SRAM_WE_N <= 1'b1;
         dq_oe     <= 1'b0;
         dq_out    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (request) begin
                  state     <= S_LOW;
                  SRAM_ADDR <= {sram_word(address, BASE_ADDR), 1'b0};
                  SRAM_WE_N <= ~wr_en;
                  dq_oe     <= wr_en;
                  dq_out    <= write_data[15:0];
               end
            end
            S_LOW: begin
               if (terminal) begin
                  state     <= S_HIGH;
                  SRAM_ADDR <= {word, 1'b1};
                  dq_out    <= wdata_hi;
                  if (!op_write) read_data[15:0] <= SRAM_DQ;
               end
            end
            S_HIGH: begin
               if (terminal) begin
                  state     <= S_DONE;
                  SRAM_WE_N <= 1'b1;
                  dq_oe     <= 1'b0;
                  if (!op_write) read_data[31:16] <= SRAM_DQ;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Pipeline freeze: released in DONE, or in IDLE with no pending request.
   // NOTE: default assignment first so no path leaves ready unassigned (no latch).
   always_comb begin
      ready = 1'b0;
      case (state)
         S_IDLE:  ready = ~request;
         S_DONE:  ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (1 and 3 wait states), each with
// its own behavioural SRAM, checked against a word-level reference memory.
module tb_sram_controller;

   localparam logic [31:0] BASE = 32'd1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en      [2];
   logic        wr_en      [2];
   logic [31:0] address    [2];
   logic [31:0] write_data [2];
   logic [31:0] read_data  [2];
   logic        ready      [2];
   logic [17:0] sram_addr  [2];
   logic        we_n       [2];
   logic        ce_n       [2];
   logic        oe_n       [2];
   logic        ub_n       [2];
   logic        lb_n       [2];
   wire  [15:0] dq0;
   wire  [15:0] dq1;

   logic [15:0] mem0 [262144];
   logic [15:0] mem1 [262144];

   logic [31:0] ref_mem [int];
   logic [31:0] last_rd [2];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
      .address(address[0]), .write_data(write_data[0]),
      .read_data(read_data[0]), .ready(ready[0]), .SRAM_DQ(dq0),
      .SRAM_ADDR(sram_addr[0]), .SRAM_WE_N(we_n[0]), .SRAM_CE_N(ce_n[0]),
      .SRAM_OE_N(oe_n[0]), .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0]));

   sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
      .address(address[1]), .write_data(write_data[1]),
      .read_data(read_data[1]), .ready(ready[1]), .SRAM_DQ(dq1),
      .SRAM_ADDR(sram_addr[1]), .SRAM_WE_N(we_n[1]), .SRAM_CE_N(ce_n[1]),
      .SRAM_OE_N(oe_n[1]), .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1]));

   // Asynchronous SRAM models: drive data while WE_N is high, store while low.
   assign dq0 = we_n[0] ? mem0[sram_addr[0]] : 16'bz;
   assign dq1 = we_n[1] ? mem1[sram_addr[1]] : 16'bz;

   always @(posedge clk) if (we_n[0] === 1'b0) mem0[sram_addr[0]] <= dq0;
   always @(posedge clk) if (we_n[1] === 1'b0) mem1[sram_addr[1]] <= dq1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int wait_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Byte address -> 32-bit word index inside the 2^17-word SRAM window.
   function automatic logic [16:0] word_of(input logic [31:0] a);
      return 17'(((a - BASE) / 4) % 131072);
   endfunction

   function automatic int key(input int k, input logic [16:0] w);
      return k * 131072 + int'(w);
   endfunction

   function automatic logic [31:0] ref_read(input int k, input logic [16:0] w);
      return ref_mem.exists(key(k, w)) ? ref_mem[key(k, w)] : 32'd0;
   endfunction

   function automatic logic [15:0] mem_rd(input int k, input logic [17:0] a);
      return (k == 0) ? mem0[a] : mem1[a];
   endfunction

   function automatic logic [15:0] dq_of(input int k);
      return (k == 0) ? dq0 : dq1;
   endfunction

   // One complete access starting in an IDLE cycle; returns at the next IDLE.
   task automatic access(input int k, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic hold, input logic move_addr);
      int          w;
      logic [16:0] wd;
      logic [31:0] exp_rd;
      logic        half;
      w  = wait_of(k);
      wd = word_of(addr);
      exp_rd = wr ? last_rd[k] : ref_read(k, wd);
      rd_en[k] = rd; wr_en[k] = wr; address[k] = addr; write_data[k] = data;
      #1 check("ready_on_request", ready[k], 1'b0);
      for (int c = 1; c <= 2 * w + 1; c++) begin
         @(negedge clk);
         if (c == 1 && move_addr) begin
            address[k] = 32'd2048;
            write_data[k] = ~data;
         end
         if (c <= 2 * w) begin
            half = (c > w);
            check("ready_busy", ready[k], 1'b0);
            check("sram_addr", sram_addr[k], {wd, half});
            check("we_n", we_n[k], !wr);
            if (wr) check("dq_write", dq_of(k), half ? data[31:16] : data[15:0]);
         end else begin
            check("ready_done", ready[k], 1'b1);
            check("read_data", read_data[k], exp_rd);
            check("we_n_done", we_n[k], 1'b1);
            if (wr) check("sram_word", {mem_rd(k, {wd, 1'b1}), mem_rd(k, {wd, 1'b0})}, data);
            if (!hold) begin
               rd_en[k] = 1'b0;
               wr_en[k] = 1'b0;
            end
         end
      end
      if (wr) ref_mem[key(k, wd)] = data;
      else    last_rd[k] = exp_rd;
      @(negedge clk);
      if (!hold) check("ready_idle", ready[k], 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      logic        h;
      int          op;

      for (int i = 0; i < 262144; i++) begin
         mem0[i] = 16'h0000;
         mem1[i] = 16'h0000;
      end
      mem0[4] = 16'h5678; mem0[5] = 16'h1234;
      mem1[4] = 16'h5678; mem1[5] = 16'h1234;
      ref_mem[key(0, 17'd2)] = 32'h1234_5678;
      ref_mem[key(1, 17'd2)] = 32'h1234_5678;
      for (int k = 0; k < 2; k++) begin
         rd_en[k] = 1'b0; wr_en[k] = 1'b0; address[k] = 32'd0; write_data[k] = 32'd0;
         last_rd[k] = 32'd0;
      end

      // Reset held two cycles with a pending read.
      rst = 1'b1;
      rd_en[0] = 1'b1;
      address[0] = 32'd1032;
      repeat (2) begin
         @(negedge clk);
         check("rst_ready_req", ready[0], 1'b0);
         check("rst_ready_idle", ready[1], 1'b1);
         check("rst_we_n", we_n[0], 1'b1);
         check("rst_read_data", read_data[0], 32'd0);
         check("rst_sram_addr", sram_addr[0], 18'd0);
         check("rst_dq_released", dq0, mem0[0]);
      end
      check("tied_pins", {28'd0, ce_n[0], oe_n[0], ub_n[0], lb_n[0]}, 32'd0);
      rst = 1'b0;

      // Pending read starts after release; then write, read-back, persistence.
      access(0, 1'b0, 1'b1, 32'd1032, 32'd0, 1'b0, 1'b0);
      access(0, 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b0, 1'b0);
      access(0, 1'b0, 1'b1, 32'd1024, 32'd0, 1'b0, 1'b0);

      // Three wait states.
      access(1, 1'b1, 1'b0, 32'd1028, 32'hA5A5_0F0F, 1'b0, 1'b0);
      access(1, 1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, 1'b0);

      // Simultaneous request (write wins) with inputs moved during LOW.
      access(0, 1'b1, 1'b1, 32'd1036, 32'h0BAD_F00D, 1'b0, 1'b1);
      access(0, 1'b0, 1'b1, 32'd1036, 32'd0, 1'b0, 1'b0);
      access(1, 1'b1, 1'b1, 32'd1036, 32'h7777_1111, 1'b0, 1'b1);

      // Held request starts a second access directly from IDLE.
      access(0, 1'b0, 1'b1, 32'd1024, 32'd0, 1'b1, 1'b0);
      access(0, 1'b0, 1'b1, 32'd1032, 32'd0, 1'b0, 1'b0);

      // Reset during the HIGH half of a write.
      wr_en[0] = 1'b1; address[0] = BASE + 32'd400; write_data[0] = 32'hCAFE_F00D;
      @(negedge clk);
      @(negedge clk);
      check("mid_high_addr", sram_addr[0], {17'd100, 1'b1});
      check("mid_high_we_n", we_n[0], 1'b0);
      rst = 1'b1;
      wr_en[0] = 1'b0;
      @(negedge clk);
      check("mid_rst_we_n", we_n[0], 1'b1);
      check("mid_rst_ready", ready[0], 1'b1);
      check("mid_rst_sram_addr", sram_addr[0], 18'd0);
      check("mid_rst_dq_released", dq0, mem0[0]);
      check("mid_rst_read_data", read_data[0], 32'd0);
      last_rd[0] = 32'd0;
      rst = 1'b0;
      @(negedge clk);
      access(0, 1'b0, 1'b1, 32'd1032, 32'd0, 1'b0, 1'b0);
      access(0, 1'b1, 1'b0, BASE + 32'd400, 32'h0102_0304, 1'b0, 1'b0);
      access(0, 1'b0, 1'b1, BASE + 32'd400, 32'd0, 1'b0, 1'b0);

      // Randomised accesses, including out-of-window addresses that wrap.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) a = $urandom();
            else a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            h = (i != 23) && ($urandom_range(0, 3) == 0);
            access(k, op != 0, op != 1, a, $urandom(), h, $urandom_range(0, 1) == 1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
